// File: rtl/err_power_monitor.sv
// -----------------------------------------------------------------------------
// err_power_monitor
//
// Purpose:
//   Watches the signed error stream of an adaptive FIR and reports the
//   mean-square error over windows of 2**LOG2_WIN valid samples. It also
//   tracks convergence. The monitor locks once N_CONSEC consecutive windows
//   have an MSE strictly below i_threshold. It drops lock on the first window
//   whose MSE is at or above i_threshold.
//
// Ports:
//   i_clk        in   1        clock, rising edge
//   i_rst_n      in   1        asynchronous active-low reset
//   i_en         in   1        monitor enable; low forces IDLE and clears counters
//   i_valid      in   1        qualifier for i_err
//   i_err        in   NB_DATA  signed error sample, fixed point (NB_DATA,NB_DATA-1)
//   i_threshold  in   NB_DATA  unsigned MSE threshold U(NB_DATA,NB_DATA-1)
//   o_mse        out  NB_DATA  unsigned windowed MSE U(NB_DATA,NB_DATA-1)
//   o_mse_valid  out  1        one-cycle pulse when o_mse is updated
//   o_converged  out  1        level, high while the monitor is LOCKED
//   o_lost       out  1        one-cycle pulse on the LOCKED -> TRACK transition
// -----------------------------------------------------------------------------
module err_power_monitor #(
  parameter int NB_DATA  = 16,
  parameter int LOG2_WIN = 4,
  parameter int N_CONSEC = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_err,
  input  logic [NB_DATA-1:0] i_threshold,
  output logic [NB_DATA-1:0] o_mse,
  output logic               o_mse_valid,
  output logic               o_converged,
  output logic               o_lost
);

  localparam int SQ_W  = 2 * NB_DATA;
  localparam int ACC_W = NB_DATA + LOG2_WIN;
  localparam int CNT_W = 8;

  // Sample index of the last sample in a window (all ones).
  localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;
  localparam logic [CNT_W-1:0]    LOCK_CNT = CNT_W'(N_CONSEC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: square the error sample.
  // ---------------------------------------------------------------------------
  logic signed [SQ_W-1:0] sq_full;
  logic [NB_DATA-1:0]     sq_r;
  logic                   sq_v;

  // The product of two (N,N-1) numbers is (2N,2N-2). Bit 2N-1 carries only
  // a redundant sign. The (N,N-1) square therefore sits in bits
  // [2N-2 -: N]. The largest square (-1.0)^2 maps to exactly 0x8000 and
  // needs no saturation.
  assign sq_full = $signed(i_err) * $signed(i_err);

  logic unused_sq_bits;
  assign unused_sq_bits = ^{sq_full[SQ_W-1], sq_full[NB_DATA-2:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sq_r <= '0;
      sq_v <= 1'b0;
    end else begin
      // A disabled monitor must not leave a squared sample in flight. Such a
      // sample would leak into the first window after re-enable.
      sq_v <= i_en & i_valid;
      if (i_en && i_valid) begin
        sq_r <= sq_full[SQ_W-2 -: NB_DATA];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: window accumulation.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [LOG2_WIN-1:0] sample_cnt;
  logic                win_end;
  logic [NB_DATA-1:0]  mean;
  logic                below;

  // The accumulator is NB_DATA+LOG2_WIN bits wide. It holds 2**LOG2_WIN
  // squares of at most 0x8000 and so cannot overflow.
  assign acc_sum = acc + {{LOG2_WIN{1'b0}}, sq_r};

  // The window closes on the edge that absorbs its last squared sample.
  assign win_end = i_en & sq_v & (sample_cnt == WIN_LAST);

  // A shift right by LOG2_WIN with truncation is a plain bit select.
  assign mean  = acc_sum[LOG2_WIN +: NB_DATA];
  assign below = (mean < i_threshold);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (!i_en) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (sq_v) begin
      if (win_end) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        acc        <= acc_sum;
        sample_cnt <= sample_cnt + LOG2_WIN'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Convergence FSM.
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             lost_next;

  // cnt never exceeds N_CONSEC-1, which is at most 254, so the increment
  // fits in CNT_W bits.
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lost_next  = 1'b0;

    if (!i_en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = TRACK;
          cnt_next   = '0;
        end

        TRACK: begin
          if (win_end) begin
            if (below) begin
              if (cnt_inc == LOCK_CNT) begin
                state_next = LOCKED;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_inc;
              end
            end else begin
              // An equal or higher window breaks the run of good windows.
              cnt_next = '0;
            end
          end
        end

        LOCKED: begin
          if (win_end && !below) begin
            state_next = TRACK;
            cnt_next   = '0;
            lost_next  = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign o_converged = (state == LOCKED);

  // ---------------------------------------------------------------------------
  // Output registers. o_mse keeps its last value while disabled. The pulse
  // outputs are cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mse       <= '0;
      o_mse_valid <= 1'b0;
      o_lost      <= 1'b0;
    end else if (!i_en) begin
      o_mse_valid <= 1'b0;
      o_lost      <= 1'b0;
    end else begin
      o_mse_valid <= win_end;
      o_lost      <= lost_next;
      if (win_end) begin
        o_mse <= mean;
      end
    end
  end

endmodule

// File: tb/tb_err_power_monitor.sv
module tb_err_power_monitor;

  localparam int NB   = 16;
  localparam int L2W  = 4;
  localparam int WIN  = 16;
  localparam int NC   = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic          i_valid;
  logic [NB-1:0] i_err;
  logic [NB-1:0] i_threshold;
  logic [NB-1:0] o_mse;
  logic          o_mse_valid;
  logic          o_converged;
  logic          o_lost;

  int checks   = 0;
  int failures = 0;

  err_power_monitor #(.NB_DATA(NB), .LOG2_WIN(L2W), .N_CONSEC(NC)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_valid     (i_valid),
    .i_err       (i_err),
    .i_threshold (i_threshold),
    .o_mse       (o_mse),
    .o_mse_valid (o_mse_valid),
    .o_converged (o_converged),
    .o_lost      (o_lost)
  );

  always #5 i_clk = ~i_clk;

  // Observed outputs packed as {valid, lost, converged, mse}.
  wire [18:0] obs = {o_mse_valid, o_lost, o_converged, o_mse};

  // ---------------------------------------------------------------------------
  // Reference model. It collects squares into a window, takes the floor of
  // the mean, and counts good windows. Squares take one edge in flight.
  // ---------------------------------------------------------------------------
  bit            pend_v;
  logic [NB-1:0] pend_sq;
  int            win_n;
  longint        win_sum;
  bit            m_locked;
  int            m_cnt;
  logic [NB-1:0] m_mse;
  bit            e_valid;
  bit            e_lost;
  logic [18:0]   exp_vec;
  int            cyc = 0;

  function automatic logic [NB-1:0] sq_of(input logic [NB-1:0] err);
    longint e;
    longint p;
    e = longint'($signed(err));
    p = e * e;
    return NB'((p >> 15) & 64'hFFFF);
  endfunction

  task automatic model_reset();
    pend_v = 0; pend_sq = '0; win_n = 0; win_sum = 0;
    m_locked = 0; m_cnt = 0; m_mse = '0; e_valid = 0; e_lost = 0;
    exp_vec = '0;
  endtask

  // Drive one cycle, advance the model over the edge, then settle #1.
  task automatic step(input bit en, input bit v, input logic [NB-1:0] err);
    longint mean;
    i_en = en; i_valid = v; i_err = err;
    @(posedge i_clk);
    cyc++;
    e_valid = 0; e_lost = 0;
    if (!en) begin
      pend_v = 0; win_n = 0; win_sum = 0; m_locked = 0; m_cnt = 0;
    end else begin
      if (pend_v) begin
        win_sum += longint'(pend_sq);
        win_n++;
        if (win_n == WIN) begin
          mean = win_sum / WIN;
          m_mse = NB'(mean);
          e_valid = 1;
          if (mean < longint'(i_threshold)) begin
            if (!m_locked) begin
              m_cnt++;
              if (m_cnt == NC) begin m_locked = 1; m_cnt = 0; end
            end
          end else begin
            e_lost = m_locked;
            m_locked = 0;
            m_cnt = 0;
          end
          win_n = 0; win_sum = 0;
        end
      end
      pend_v = v;
      pend_sq = sq_of(err);
    end
    exp_vec = {e_valid, e_lost, m_locked, m_mse};
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_rst_n = 0; i_en = 0; i_valid = 0; i_err = '0; i_threshold = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_mse !== 16'h0000) begin failures++; $display("FAIL reset_mse got=%h exp=0000", o_mse); end
    checks++;
    if (o_mse_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_mse_valid); end
    checks++;
    if (o_converged !== 1'b0) begin failures++; $display("FAIL reset_conv got=%b exp=0", o_converged); end
    checks++;
    if (o_lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", o_lost); end
    @(negedge i_clk);
    i_rst_n = 1;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_basic_window();
    int pulse_at;
    pulse_at = -1;
    i_threshold = 16'h0000;
    for (int k = 1; k <= 19; k++) begin
      step(1, k <= 16, 16'h4000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid && pulse_at < 0) pulse_at = k;
    end
    checks++;
    if (pulse_at != 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", pulse_at); end
    checks++;
    if (o_mse !== 16'h2000) begin failures++; $display("FAIL basic_mse got=%h exp=2000", o_mse); end
    $display("test_basic_window pulse_step=%0d mse=%h", pulse_at, o_mse);
  endtask

  task automatic test_extremes();
    for (int k = 1; k <= 18; k++) begin
      step(1, k <= 16, 16'h8000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL ext_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    checks++;
    if (o_mse !== 16'h8000) begin failures++; $display("FAIL ext_max_mse got=%h exp=8000", o_mse); end
    $display("test_extremes full_scale mse=%h", o_mse);
    for (int k = 1; k <= 18; k++) begin
      step(1, k <= 16, (k % 2) ? 16'h4000 : 16'hC000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL ext_alt_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    checks++;
    if (o_mse !== 16'h2000) begin failures++; $display("FAIL ext_alt_mse got=%h exp=2000", o_mse); end
    $display("test_extremes alternating mse=%h", o_mse);
  endtask

  task automatic test_lock_and_loss();
    int pulses;
    int lost_seen;
    step(0, 0, '0);
    i_threshold = 16'h0100;
    pulses = 0;
    for (int k = 1; k <= 4 * WIN + 2; k++) begin
      step(1, k <= 4 * WIN, 16'h0000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid) begin
        pulses++;
        checks++;
        if (o_converged !== (pulses >= NC)) begin
          failures++; $display("FAIL lock_timing pulse=%0d got=%b exp=%b", pulses, o_converged, pulses >= NC);
        end
      end
    end
    $display("test_lock pulses=%0d converged=%b", pulses, o_converged);
    lost_seen = 0;
    for (int k = 1; k <= WIN + 2; k++) begin
      step(1, k <= WIN, (k == 5) ? 16'h7FFF : 16'h0000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL loss_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid) begin
        lost_seen++;
        checks++;
        if ({o_lost, o_converged, o_mse} !== {1'b1, 1'b0, 16'h07FF}) begin
          failures++; $display("FAIL loss_pulse got lost=%b conv=%b mse=%h exp lost=1 conv=0 mse=07ff", o_lost, o_converged, o_mse);
        end
      end
    end
    checks++;
    if (lost_seen != 1) begin failures++; $display("FAIL loss_count got=%0d exp=1", lost_seen); end
    pulses = 0;
    for (int k = 1; k <= 4 * WIN + 2; k++) begin
      step(1, k <= 4 * WIN, 16'h0000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL relock_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid) pulses++;
    end
    checks++;
    if (o_converged !== 1'b1) begin failures++; $display("FAIL relock got=%b exp=1", o_converged); end
    $display("test_loss lost_pulses=%0d relock=%b", lost_seen, o_converged);
  endtask

  task automatic test_random_gaps();
    int nvalid;
    int pulses;
    int conv_seen;
    int budget;
    bit v;
    step(0, 0, '0);
    i_threshold = 16'h0800;
    nvalid = 0; pulses = 0; conv_seen = 0; budget = 0;
    while (nvalid < 5 * WIN && budget < 1000) begin
      v = 1'($urandom_range(0, 1));
      step(1, v, 16'h2000);
      if (v) nvalid++;
      budget++;
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL gap_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid) begin
        pulses++;
        checks++;
        if (o_mse !== 16'h0800) begin failures++; $display("FAIL gap_mse got=%h exp=0800", o_mse); end
      end
      if (o_converged) conv_seen++;
    end
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 16'h2000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL gap_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (o_mse_valid) pulses++;
      if (o_converged) conv_seen++;
    end
    checks++;
    if (budget >= 1000) begin failures++; $display("FAIL gap_budget got=%0d exp<1000", budget); end
    checks++;
    if (pulses != 5) begin failures++; $display("FAIL gap_pulses got=%0d exp=5", pulses); end
    checks++;
    if (conv_seen != 0) begin failures++; $display("FAIL gap_equal_thr_locked got=%0d exp=0", conv_seen); end
    $display("test_random_gaps valid=%0d pulses=%0d", nvalid, pulses);

    // Mixed random traffic with occasional enable drops.
    i_threshold = NB'($urandom_range(16'h0080, 16'h0400));
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) ? NB'($urandom_range(0, 16'h0FFF)) : NB'(-$urandom_range(0, 16'h0FFF))));
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    $display("test_random_mixed thr=%h last_mse=%h", i_threshold, o_mse);
  endtask

  task automatic test_midwindow_abort();
    step(0, 0, '0);
    i_threshold = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      step(1, 1, 16'h4000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    #2 i_rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL abort_rst_outputs got=%h exp=00000", obs); end
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL abort_rst_hold got=%h exp=00000", obs); end
    @(negedge i_clk);
    i_rst_n = 1;
    for (int k = 1; k <= WIN + 2; k++) begin
      step(1, k <= WIN, 16'h2000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL abort_post cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    checks++;
    if (o_mse !== 16'h0800) begin failures++; $display("FAIL abort_post_mse got=%h exp=0800", o_mse); end
    $display("test_midwindow_reset mse=%h", o_mse);

    for (int k = 0; k < 7; k++) step(1, 1, 16'h4000);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 16'h4000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL en_drop_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      checks++;
      if ({o_mse_valid, o_mse} !== {1'b0, 16'h0800}) begin
        failures++; $display("FAIL en_drop_hold got v=%b mse=%h exp v=0 mse=0800", o_mse_valid, o_mse);
      end
    end
    for (int k = 1; k <= WIN + 2; k++) begin
      step(1, k <= WIN, 16'h8000);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL en_post cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    end
    checks++;
    if (o_mse !== 16'h8000) begin failures++; $display("FAIL en_post_mse got=%h exp=8000", o_mse); end
    $display("test_midwindow_enable mse=%h", o_mse);
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_extremes();
    test_lock_and_loss();
    test_random_gaps();
    test_midwindow_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
